// File: rtl/nfi_engine_if.sv
// NFI engine handshake, cell edit and display read signals.
interface nfi_engine_if #(
    parameter int FIELD_W  = 16,
    parameter int FIELD_H  = 16,
    parameter int GEN_BITS = 16
);
    localparam int XW = $clog2(FIELD_W);
    localparam int YW = $clog2(FIELD_H);

    logic                i_go;
    logic                o_NFI_allowed;
    logic                o_done;
    logic                i_wr_en;
    logic [XW-1:0]       i_wr_x;
    logic [YW-1:0]       i_wr_y;
    logic                i_wr_val;
    logic                i_clear;
    logic [XW-1:0]       i_rd_x;
    logic [YW-1:0]       i_rd_y;
    logic                o_rd_val;
    logic [GEN_BITS-1:0] o_gen_cnt;

    modport master (
        output i_go, i_wr_en, i_wr_x, i_wr_y, i_wr_val, i_clear, i_rd_x, i_rd_y,
        input  o_NFI_allowed, o_done, o_rd_val, o_gen_cnt
    );

    modport slave (
        input  i_go, i_wr_en, i_wr_x, i_wr_y, i_wr_val, i_clear, i_rd_x, i_rd_y,
        output o_NFI_allowed, o_done, o_rd_val, o_gen_cnt
    );
endinterface

// File: rtl/nfi_engine.sv
// Game of Life engine: one generation per accepted go, one cell per clock,
// visible field kept stable until the whole generation commits.
module nfi_engine #(
    parameter int FIELD_W  = 16,
    parameter int FIELD_H  = 16,
    parameter int WRAP     = 1,
    parameter int GEN_BITS = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    nfi_engine_if.slave   bus
);
    localparam int XW = $clog2(FIELD_W);
    localparam int YW = $clog2(FIELD_H);

    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

    state_t              state, state_n;
    logic [FIELD_W-1:0]  cur [FIELD_H];
    logic [FIELD_W-1:0]  nxt [FIELD_H];
    logic [XW-1:0]       sx;
    logic [YW-1:0]       sy;
    logic [3:0]          nbr_cnt;
    logic                new_val;
    logic                last_cell;
    logic                wr_in_range;
    logic                rd_in_range;
    logic [GEN_BITS-1:0] gen_q;
    logic                done_q;

    // Neighbour lookup with edge handling: wrap around or treat as dead.
    function automatic logic cell_at(input int x, input int y);
        int  xx;
        int  yy;
        logic ok;
        xx = x;
        yy = y;
        ok = 1'b1;
        if (xx < 0) begin
            if (WRAP != 0) xx = FIELD_W - 1; else ok = 1'b0;
        end else if (xx >= FIELD_W) begin
            if (WRAP != 0) xx = 0; else ok = 1'b0;
        end
        if (yy < 0) begin
            if (WRAP != 0) yy = FIELD_H - 1; else ok = 1'b0;
        end else if (yy >= FIELD_H) begin
            if (WRAP != 0) yy = 0; else ok = 1'b0;
        end
        if (!ok) return 1'b0;
        return cur[YW'(yy)][XW'(xx)];
    endfunction

    assign last_cell   = (sx == XW'(FIELD_W - 1)) && (sy == YW'(FIELD_H - 1));
    assign wr_in_range = (int'(bus.i_wr_x) < FIELD_W) && (int'(bus.i_wr_y) < FIELD_H);
    assign rd_in_range = (int'(bus.i_rd_x) < FIELD_W) && (int'(bus.i_rd_y) < FIELD_H);

    assign bus.o_NFI_allowed = (state == IDLE);
    assign bus.o_done        = done_q;
    assign bus.o_gen_cnt     = gen_q;
    assign bus.o_rd_val      = rd_in_range ? cur[bus.i_rd_y][bus.i_rd_x] : 1'b0;

    // Live neighbour count of the cell under the sweep pointer.
    always_comb begin
        nbr_cnt = '0;
        for (int unsigned k = 0; k < 9; k++) begin
            if (k != 4)
                nbr_cnt = nbr_cnt + 4'(cell_at(int'(sx) + int'(k % 3) - 1,
                                               int'(sy) + int'(k / 3) - 1));
        end
        new_val = (nbr_cnt == 4'd3) || (cur[sy][sx] && (nbr_cnt == 4'd2));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic: go only accepted in IDLE, sweep ends on last cell.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.i_go) state_n = CALC;
            CALC:    if (last_cell) state_n = COMMIT;
            COMMIT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Raster sweep writing the shadow buffer, x fastest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx  <= '0;
            sy  <= '0;
            nxt <= '{default: '0};
        end else if (state == CALC) begin
            nxt[sy][sx] <= new_val;
            if (sx == XW'(FIELD_W - 1)) begin
                sx <= '0;
                sy <= sy + YW'(1);
            end else begin
                sx <= sx + XW'(1);
            end
        end else begin
            sx <= '0;
            sy <= '0;
        end
    end

    // Visible field: commit, or idle-only edits with clear taking priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= '{default: '0};
        end else if (state == COMMIT) begin
            cur <= nxt;
        end else if (state == IDLE) begin
            if (bus.i_clear)
                cur <= '{default: '0};
            else if (bus.i_wr_en && wr_in_range)
                cur[bus.i_wr_y][bus.i_wr_x] <= bus.i_wr_val;
        end
    end

    // Generation counter and done pulse in the first IDLE cycle after commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == COMMIT);
            if (state == COMMIT) gen_q <= gen_q + GEN_BITS'(1);
        end
    end
endmodule

// File: tb/tb_nfi_engine.sv
// Bench for nfi_engine: a wrapping and a non-wrapping instance driven in
// lockstep and compared cell-by-cell against a modular-arithmetic Life model.
module tb_nfi_engine;
    localparam int W  = 16;
    localparam int H  = 16;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic go = 1'b0, wr_en = 1'b0, wr_val = 1'b0, clear = 1'b0;
    logic [XW-1:0] wr_x = '0, rd_x = '0;
    logic [YW-1:0] wr_y = '0, rd_y = '0;

    int n_checks = 0;
    int n_fail   = 0;
    bit mdl [2][H][W];   // [0] toroidal, [1] dead border
    int gen_m = 0;

    always #5 clk = ~clk;

    nfi_engine_if #(.FIELD_W(W), .FIELD_H(H), .GEN_BITS(16)) bw ();
    nfi_engine_if #(.FIELD_W(W), .FIELD_H(H), .GEN_BITS(16)) bn ();

    assign bw.i_go = go;     assign bn.i_go = go;
    assign bw.i_wr_en = wr_en; assign bn.i_wr_en = wr_en;
    assign bw.i_wr_x = wr_x; assign bn.i_wr_x = wr_x;
    assign bw.i_wr_y = wr_y; assign bn.i_wr_y = wr_y;
    assign bw.i_wr_val = wr_val; assign bn.i_wr_val = wr_val;
    assign bw.i_clear = clear; assign bn.i_clear = clear;
    assign bw.i_rd_x = rd_x; assign bn.i_rd_x = rd_x;
    assign bw.i_rd_y = rd_y; assign bn.i_rd_y = rd_y;

    nfi_engine #(.FIELD_W(W), .FIELD_H(H), .WRAP(1), .GEN_BITS(16)) dut_w (
        .clk(clk), .rst_n(rst_n), .bus(bw));
    nfi_engine #(.FIELD_W(W), .FIELD_H(H), .WRAP(0), .GEN_BITS(16)) dut_n (
        .clk(clk), .rst_n(rst_n), .bus(bn));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int m = 0; m < 2; m++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) mdl[m][y][x] = 1'b0;
    endtask

    task automatic model_set(input int x, input int y, input bit v);
        mdl[0][y][x] = v;
        mdl[1][y][x] = v;
    endtask

    // Next generation from the Life rules: modulo indices for the torus,
    // skipped indices for the bounded field.
    task automatic model_step();
        bit tmp [H][W];
        for (int m = 0; m < 2; m++) begin
            for (int y = 0; y < H; y++) begin
                for (int x = 0; x < W; x++) begin
                    int n = 0;
                    for (int dy = -1; dy <= 1; dy++) begin
                        for (int dx = -1; dx <= 1; dx++) begin
                            int xx = x + dx;
                            int yy = y + dy;
                            if (dx == 0 && dy == 0) continue;
                            if (m == 0) n += int'(mdl[0][(yy + H) % H][(xx + W) % W]);
                            else if (xx >= 0 && xx < W && yy >= 0 && yy < H)
                                n += int'(mdl[1][yy][xx]);
                        end
                    end
                    tmp[y][x] = (n == 3) || (mdl[m][y][x] && n == 2);
                end
            end
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) mdl[m][y][x] = tmp[y][x];
        end
        gen_m++;
    endtask

    task automatic write_cell(input int x, input int y, input bit v);
        wr_en = 1'b1; wr_x = XW'(x); wr_y = YW'(y); wr_val = v;
        tick();
        wr_en = 1'b0;
        model_set(x, y, v);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
    endtask

    task automatic peek(input string tag, input int x, input int y);
        rd_x = XW'(x); rd_y = YW'(y);
        #1;
        check({tag, "_w"}, 32'(bw.o_rd_val), 32'(mdl[0][y][x]));
        check({tag, "_n"}, 32'(bn.o_rd_val), 32'(mdl[1][y][x]));
    endtask

    task automatic compare_field(input string tag);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) peek(tag, x, y);
    endtask

    // One generation: go pulse (optionally with a same-edge write), busy-length
    // measurement, optional mid-sweep edit/go attempt, done pulse and counter.
    task automatic run_gen(input bit inject, input bit wr_with_go, input int wx, input int wy);
        int busy = 0;
        int early_done = 0;
        go = 1'b1;
        if (wr_with_go) begin
            wr_en = 1'b1; wr_x = XW'(wx); wr_y = YW'(wy); wr_val = 1'b1;
            model_set(wx, wy, 1'b1);
        end
        tick();
        go = 1'b0; wr_en = 1'b0;
        while (bw.o_NFI_allowed == 1'b0 && busy < 1000) begin
            busy++;
            if (bw.o_done || bn.o_done) early_done++;
            if (busy == 100)
                check("rd_during_calc", 32'(bw.o_rd_val), 32'(mdl[0][rd_y][rd_x]));
            if (inject && busy == 50) begin
                go = 1'b1; wr_en = 1'b1; wr_x = XW'(5); wr_y = YW'(5);
                wr_val = 1'b1; clear = 1'b1;
            end
            tick();
            go = 1'b0; wr_en = 1'b0; clear = 1'b0;
        end
        check("busy_cycles", 32'(busy), 32'(W * H + 1));
        check("early_done", 32'(early_done), 32'd0);
        check("done_w", 32'(bw.o_done), 32'd1);
        check("done_n", 32'(bn.o_done), 32'd1);
        check("allowed_n", 32'(bn.o_NFI_allowed), 32'd1);
        model_step();
        tick();
        check("done_drop", 32'(bw.o_done), 32'd0);
        check("gen_cnt", 32'(bw.o_gen_cnt), 32'(gen_m));
        repeat (3) begin
            tick();
            check("no_extra_done", 32'(bw.o_done), 32'd0);
            check("stay_idle", 32'(bw.o_NFI_allowed), 32'd1);
        end
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        tick(); tick();
        check("rst_allowed", 32'(bw.o_NFI_allowed), 32'd1);
        check("rst_done", 32'(bw.o_done), 32'd0);
        check("rst_gen", 32'(bw.o_gen_cnt), 32'd0);
        compare_field("rst_field");
        rst_n = 1'b1;
        tick();

        // Blinker oscillates between horizontal and vertical.
        write_cell(1, 2, 1); write_cell(2, 2, 1); write_cell(3, 2, 1);
        rd_x = XW'(1); rd_y = YW'(2);
        run_gen(1'b0, 1'b0, 0, 0);
        compare_field("blinker1");
        check("blinker_v", {29'd0, bw.o_rd_val, 2'd0}, 32'd0);
        peek("blinker_21", 2, 1);
        check("blinker_21_lit", 32'(bw.o_rd_val), 32'd1);
        run_gen(1'b0, 1'b0, 0, 0);
        compare_field("blinker2");
        check("blinker_gen2", 32'(bw.o_gen_cnt), 32'd2);

        // Edge behaviour: toroidal vs dead border.
        do_clear();
        write_cell(15, 0, 1); write_cell(0, 0, 1); write_cell(1, 0, 1);
        run_gen(1'b0, 1'b0, 0, 0);
        compare_field("wrap");
        peek("wrap_0_15", 0, 15);
        check("wrap_0_15_w", 32'(bw.o_rd_val), 32'd1);
        check("wrap_0_15_n", 32'(bn.o_rd_val), 32'd0);

        // Busy guard: mid-sweep go/write/clear ignored.
        do_clear();
        write_cell(9, 10, 1); write_cell(10, 10, 1); write_cell(11, 10, 1);
        run_gen(1'b1, 1'b0, 0, 0);
        compare_field("busy_guard");
        peek("guard_55", 5, 5);
        check("guard_55_lit", 32'(bw.o_rd_val), 32'd0);

        // Clear beats write; write with go is included in the generation.
        write_cell(4, 4, 1);
        clear = 1'b1; wr_en = 1'b1; wr_x = XW'(3); wr_y = YW'(3); wr_val = 1'b1;
        tick();
        clear = 1'b0; wr_en = 1'b0;
        model_clear();
        compare_field("clear_wins");
        run_gen(1'b0, 1'b1, 7, 7);
        compare_field("wr_with_go");

        // Random soups over a few generations.
        for (int r = 0; r < 2; r++) begin
            do_clear();
            for (int i = 0; i < 80; i++)
                write_cell(int'($urandom_range(W - 1)), int'($urandom_range(H - 1)),
                           bit'($urandom_range(3) != 0));
            compare_field("rand_seed");
            for (int g = 0; g < 3; g++) begin
                run_gen(1'b0, 1'b0, 0, 0);
                compare_field("rand_gen");
            end
        end

        // Reset mid-sweep aborts and clears everything.
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (99) tick();
        check("pre_rst_busy", 32'(bw.o_NFI_allowed), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        gen_m = 0;
        check("arst_allowed", 32'(bw.o_NFI_allowed), 32'd1);
        check("arst_done", 32'(bw.o_done), 32'd0);
        check("arst_gen", 32'(bw.o_gen_cnt), 32'd0);
        compare_field("arst_field");
        rst_n = 1'b1;
        repeat (300) begin
            tick();
            if (bw.o_done || !bw.o_NFI_allowed) check("post_rst_quiet", 32'd1, 32'd0);
        end
        check("post_rst_gen", 32'(bw.o_gen_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
